// File: rtl/nor_resp_checker.sv
// Response checker for two-input gate exercises: scores (a,b,s) samples against TRUTH_TABLE.
// Optional build macro NOR_CHK_STOP_ON_FAIL_EN adds a HALT state entered on the first mismatch.
module nor_resp_checker #(
  parameter logic [3:0] TRUTH_TABLE = 4'b0001,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_s,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       coverage,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_idx,
  output logic             done,
  output logic             error
);

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // RUN    | accepting and scoring samples
  // DONE   | all four input combinations seen, results held
  // HALT   | stopped on first mismatch (NOR_CHK_STOP_ON_FAIL_EN only)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef NOR_CHK_STOP_ON_FAIL_EN
  localparam logic [1:0] S_HALT = 2'd3;
`endif

  logic [1:0]       r_state;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [3:0]       r_cov;
  logic             r_ffv;
  logic [1:0]       r_ffi;

  logic [1:0]       w_idx;
  logic             w_exp;
  logic             w_match;
  logic             w_xfer;
  logic [3:0]       w_cov_next;
  logic [CNT_W-1:0] w_max;
  logic [1:0]       w_nstate;

  assign w_idx      = {in_a, in_b};
  assign w_exp      = TRUTH_TABLE[w_idx];
  assign w_match    = (in_s == w_exp);
  // start wins over a simultaneous sample; that sample is dropped
  assign w_xfer     = in_valid && r_in_ready && !start;
  assign w_cov_next = r_cov | (4'(1) << w_idx);
  assign w_max      = {CNT_W{1'b1}};

  always_comb begin
    w_nstate = r_state;
    if (start) begin
      w_nstate = S_RUN;
    end else if (w_xfer) begin
`ifdef NOR_CHK_STOP_ON_FAIL_EN
      if (!w_match)
        w_nstate = S_HALT;
      else if (w_cov_next == 4'hF)
        w_nstate = S_DONE;
`else
      if (w_cov_next == 4'hF)
        w_nstate = S_DONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_cov      <= '0;
      r_ffv      <= 1'b0;
      r_ffi      <= '0;
    end else begin
      r_state    <= w_nstate;
      r_in_ready <= (w_nstate == S_RUN);
      if (start) begin
        r_pass <= '0;
        r_fail <= '0;
        r_cov  <= '0;
        r_ffv  <= 1'b0;
        r_ffi  <= '0;
      end else if (w_xfer) begin
        r_cov <= w_cov_next;
        if (w_match) begin
          if (r_pass != w_max)
            r_pass <= r_pass + CNT_W'(1);
        end else begin
          if (r_fail != w_max)
            r_fail <= r_fail + CNT_W'(1);
          if (!r_ffv) begin
            r_ffv <= 1'b1;
            r_ffi <= w_idx;
          end
        end
      end
    end
  end

  assign in_ready         = r_in_ready;
  assign pass_cnt         = r_pass;
  assign fail_cnt         = r_fail;
  assign coverage         = r_cov;
  assign first_fail_valid = r_ffv;
  assign first_fail_idx   = r_ffi;
  assign done             = (r_state == S_DONE);
  assign error            = (r_fail != '0);

endmodule

// File: tb/tb_nor_resp_checker.sv
// Directed bench for nor_resp_checker: a reference model pushes expected results to a queue,
// popped and checked with immediate assertions after each clock edge.
module tb_nor_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0, in_s = 1'b0;
  logic       start2 = 1'b0, in_valid2 = 1'b0;
  logic       in_ready, first_fail_valid, done, error;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] coverage;
  logic [1:0] first_fail_idx;
  logic       in_ready2, ffv2, done2, error2;
  logic [7:0] pass2, fail2;
  logic [3:0] cov2;
  logic [1:0] ffi2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nor_resp_checker #(.TRUTH_TABLE(4'b0001), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .coverage(coverage), .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .done(done), .error(error));

  nor_resp_checker #(.TRUTH_TABLE(4'b1000), .CNT_W(8)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .pass_cnt(pass2), .fail_cnt(fail2),
    .coverage(cov2), .first_fail_valid(ffv2), .first_fail_idx(ffi2),
    .done(done2), .error(error2));

  typedef struct packed {
    logic       rdy;
    logic [7:0] pc;
    logic [7:0] fc;
    logic [3:0] cov;
    logic       ffv;
    logic [1:0] ffi;
    logic       dn;
    logic       er;
  } exp_t;

  exp_t q[$];

  // reference model: 0 IDLE, 1 RUN, 2 DONE, 3 HALT
  int         m_st = 0;
  logic [7:0] m_pc = 0, m_fc = 0;
  logic [3:0] m_cov = 0;
  logic       m_ffv = 0;
  logic [1:0] m_ffi = 0;

  function automatic exp_t model_out();
    exp_t e;
    e.rdy = (m_st == 1);
    e.pc  = m_pc;
    e.fc  = m_fc;
    e.cov = m_cov;
    e.ffv = m_ffv;
    e.ffi = m_ffi;
    e.dn  = (m_st == 2);
    e.er  = (m_fc != 0);
    return e;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_fc = 0; m_cov = 0; m_ffv = 0; m_ffi = 0;
  endtask

  task automatic model_edge(input bit st, input bit v, input bit a, input bit b, input bit s);
    logic [3:0] tt;
    logic [1:0] idx;
    bit         ok;
    tt = 4'b0001;
    if (st) begin
      model_reset();
      m_st = 1;
    end else if (v && m_st == 1) begin
      idx = {a, b};
      ok  = (s == tt[idx]);
      m_cov[idx] = 1'b1;
      if (ok) begin
        if (m_pc != 8'd255) m_pc = m_pc + 8'd1;
      end else begin
        if (m_fc != 8'd255) m_fc = m_fc + 8'd1;
        if (!m_ffv) begin m_ffv = 1'b1; m_ffi = idx; end
      end
`ifdef NOR_CHK_STOP_ON_FAIL_EN
      if (!ok) m_st = 3;
      else if (m_cov == 4'hF) m_st = 2;
`else
      if (m_cov == 4'hF) m_st = 2;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, " queue_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk({tag, " in_ready"}, in_ready, e.rdy);
    chk({tag, " pass_cnt"}, pass_cnt, e.pc);
    chk({tag, " fail_cnt"}, fail_cnt, e.fc);
    chk({tag, " coverage"}, coverage, e.cov);
    chk({tag, " ff_valid"}, first_fail_valid, e.ffv);
    chk({tag, " ff_idx"}, first_fail_idx, e.ffi);
    chk({tag, " done"}, done, e.dn);
    chk({tag, " error"}, error, e.er);
  endtask

  task automatic step(input string tag, input bit st, input bit v,
                      input bit a, input bit b, input bit s);
    @(negedge clk);
    start = st; in_valid = v; in_a = a; in_b = b; in_s = s;
    @(posedge clk);
    model_edge(st, v, a, b, s);
    q.push_back(model_out());
    #1;
    compare_pop(tag);
  endtask

  initial begin
    // reset state
    #12;
    q.push_back(model_out());
    compare_pop("reset");
    @(negedge clk); rst_n = 1'b1;
    step("idle_valid_ignored", 0, 1, 0, 0, 1);

    // all four NOR combinations, correct outputs
    step("t1_start", 1, 0, 0, 0, 0);
    step("t1_s00", 0, 1, 0, 0, 1);
    step("t1_s01", 0, 1, 0, 1, 0);
    step("t1_s10", 0, 1, 1, 0, 0);
    step("t1_s11", 0, 1, 1, 1, 0);
    step("t1_done_hold", 0, 1, 0, 0, 0);

    // one mismatch at {a,b}=11
    step("t2_start", 1, 0, 0, 0, 0);
    step("t2_s00", 0, 1, 0, 0, 1);
    step("t2_s11_bad", 0, 1, 1, 1, 1);
    step("t2_s01", 0, 1, 0, 1, 0);
    step("t2_s10", 0, 1, 1, 0, 0);
    step("t2_hold", 0, 0, 0, 0, 0);

    // saturation
    step("t3_start", 1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step("t3_sat", 0, 1, 0, 0, 1);
    chk("t3_pass_sat", pass_cnt, 8'd255);

    // start colliding with a valid sample
    step("t4_start", 1, 0, 0, 0, 0);
    step("t4_s00", 0, 1, 0, 0, 1);
    step("t4_s10", 0, 1, 1, 0, 0);
    step("t4_start_collide", 1, 1, 0, 1, 0);
    chk("t4_cov_cleared", coverage, 4'h0);
    step("t4_after", 0, 1, 1, 1, 0);

    // async reset mid-RUN
    step("t5_start", 1, 0, 0, 0, 0);
    step("t5_s00", 0, 1, 0, 0, 1);
    step("t5_s01", 0, 1, 0, 1, 0);
    step("t5_s10", 0, 1, 1, 0, 1);
    #2; rst_n = 1'b0; #1;
    model_reset();
    q.push_back(model_out());
    compare_pop("t5_async_rst");
    @(negedge clk); rst_n = 1'b1;
    step("t5_valid_ignored", 0, 1, 1, 1, 0);
    step("t5_valid_ignored2", 0, 1, 0, 0, 1);

    // AND truth table instance
    @(negedge clk); start2 = 1'b1; in_valid2 = 1'b0;
    @(negedge clk); start2 = 1'b0;
    chk("and_ready", in_ready2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1; in_a = i[1]; in_b = i[0]; in_s = (i == 3);
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    chk("and_pass", pass2, 8'd4);
    chk("and_fail", fail2, 8'd0);
    chk("and_cov", cov2, 4'hF);
    chk("and_done", done2, 1'b1);
    chk("and_ready_off", in_ready2, 1'b0);
    chk("and_error", error2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
